// File: rtl/ps2_key_serializer.sv
// ps2_key_serializer: turns MiSTer ps2_key toggle events into a PS/2 device clock/data stream.
// Latency: event to FIFO 1 cycle; FIFO to start bit 2 cycles when idle; frame 22*HALF cycles plus GAP_CYCLES idle.
// Backpressure: HOST_INHIBIT defers/aborts frames; a full FIFO drops the whole event and pulses OVERFLOW. Option macro: PS2_TYPEMATIC_EN.
module ps2_key_serializer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int PS2_HZ     = 12_500,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 4000
`ifdef PS2_TYPEMATIC_EN
    ,
    parameter int TM_DELAY   = 25_000_000,
    parameter int TM_PERIOD  = 4_600_000
`endif
) (
    input  logic        CLK50MHZ,
    input  logic        COCO_RESET_N,
    input  logic [10:0] PS2_KEY,
    input  logic        HOST_INHIBIT,
    output logic        PS2_CLK,
    output logic        PS2_DATA,
    output logic        BUSY,
    output logic        OVERFLOW
);
    localparam int HALF = CLK_HZ / (2 * PS2_HZ);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int TMAX = (HALF > GAP_CYCLES) ? HALF : GAP_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, GAP} state_t;

    // ---------------- event detect ----------------
    logic key_q;
    logic primed;
    logic evt;

    assign evt = primed && (PS2_KEY[10] != key_q);

    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            key_q  <= 1'b0;
            primed <= 1'b0;
        end else begin
            key_q  <= PS2_KEY[10];
            primed <= 1'b1;
        end
    end

    // ---------------- set-2 expansion ----------------
    logic [2:0][7:0] ev_b;
    logic [1:0]      ev_n;

    always_comb begin
        ev_b = {PS2_KEY[7:0], PS2_KEY[7:0], PS2_KEY[7:0]};
        ev_n = 2'd1;
        if (PS2_KEY[8] && !PS2_KEY[9]) begin
            ev_b[0] = 8'hE0;
            ev_b[1] = 8'hF0;
            ev_n    = 2'd3;
        end else if (PS2_KEY[8]) begin
            ev_b[0] = 8'hE0;
            ev_n    = 2'd2;
        end else if (!PS2_KEY[9]) begin
            ev_b[0] = 8'hF0;
            ev_n    = 2'd2;
        end
    end

`ifdef PS2_TYPEMATIC_EN
    // ---------------- typematic repeat ----------------
    localparam int TW = $clog2(((TM_DELAY > TM_PERIOD) ? TM_DELAY : TM_PERIOD) + 1);

    logic [TW-1:0] tm_cnt;
    logic          tm_armed;
    logic          tm_first;
    logic          tm_ext;
    logic [7:0]    tm_code;
    logic          tm_fire;

    // A real event in the same cycle always wins and re-arms the timer.
    assign tm_fire = tm_armed && !evt &&
                     (tm_cnt == (tm_first ? TW'(TM_DELAY - 1) : TW'(TM_PERIOD - 1)));

    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            tm_cnt   <= '0;
            tm_armed <= 1'b0;
            tm_first <= 1'b0;
            tm_ext   <= 1'b0;
            tm_code  <= 8'h00;
        end else if (evt) begin
            tm_armed <= PS2_KEY[9];
            tm_cnt   <= '0;
            tm_first <= 1'b1;
            tm_ext   <= PS2_KEY[8];
            tm_code  <= PS2_KEY[7:0];
        end else if (tm_armed) begin
            if (tm_fire) begin
                tm_cnt   <= '0;
                tm_first <= 1'b0;
            end else begin
                tm_cnt <= tm_cnt + TW'(1);
            end
        end
    end
`endif

    // ---------------- byte FIFO with atomic multi-byte push ----------------
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   used;
    logic [PW-1:0]   free;
    logic            fifo_ne;
    logic            push_req;
    logic [2:0][7:0] push_b;
    logic [1:0]      push_n;
    logic            fits;
    logic            push_ok;
    logic            pop;

    assign used    = wr_ptr - rd_ptr;
    assign free    = PW'(FIFO_DEPTH) - used;
    assign fifo_ne = (used != '0);

    always_comb begin
        push_req = evt;
        push_b   = ev_b;
        push_n   = ev_n;
`ifdef PS2_TYPEMATIC_EN
        if (!evt && tm_fire) begin
            push_req  = 1'b1;
            push_b    = {tm_code, tm_code, tm_code};
            push_n    = tm_ext ? 2'd2 : 2'd1;
            if (tm_ext) begin
                push_b[0] = 8'hE0;
            end
        end
`endif
    end

    // Space is judged before this cycle's pop so the decision never depends on the FSM.
    assign fits    = (free >= PW'(push_n));
    assign push_ok = push_req && fits;

    always_ff @(posedge CLK50MHZ) begin
        if (push_ok) begin
            for (int i = 0; i < 3; i++) begin
                if (i < int'(push_n)) begin
                    mem[wr_ptr[AW-1:0] + AW'(i)] <= push_b[i];
                end
            end
        end
    end

    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(push_n);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            OVERFLOW <= evt && !fits;
        end
    end

    // ---------------- frame FSM ----------------
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [3:0]    idx;
    logic [3:0]    idx_nxt;
    logic [10:0]   frame;
    logic [7:0]    hold;
    logic          hold_vld;
    logic [7:0]    load_byte;
    logic          load;
    logic          done;

    assign load_byte = hold_vld ? hold : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= 4'd0;
            frame    <= '0;
            hold     <= 8'h00;
            hold_vld <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            if (load) begin
                frame    <= {1'b1, ~^load_byte, load_byte, 1'b0};
                hold     <= load_byte;
                hold_vld <= 1'b1;
            end else if (done) begin
                hold_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        pop       = 1'b0;
        load      = 1'b0;
        done      = 1'b0;
        PS2_CLK   = 1'b1;
        PS2_DATA  = 1'b1;
        case (state)
            IDLE: begin
                if ((fifo_ne || hold_vld) && !HOST_INHIBIT) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                pop       = !hold_vld;
                load      = 1'b1;
                idx_nxt   = 4'd0;
                cnt_nxt   = '0;
                state_nxt = BIT_HI;
            end
            BIT_HI: begin
                PS2_DATA = frame[idx];
                if (HOST_INHIBIT && (idx <= 4'd9)) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(HALF - 1)) begin
                    state_nxt = BIT_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            BIT_LO: begin
                PS2_CLK  = 1'b0;
                PS2_DATA = frame[idx];
                if (HOST_INHIBIT && (idx <= 4'd9)) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(HALF - 1)) begin
                    cnt_nxt = '0;
                    if (idx == 4'd10) begin
                        state_nxt = GAP;
                        done      = 1'b1;
                    end else begin
                        idx_nxt   = idx + 4'd1;
                        state_nxt = BIT_HI;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            GAP: begin
                // After an abort the gap only starts counting once the host lets go.
                if (hold_vld && HOST_INHIBIT) begin
                    cnt_nxt = '0;
                end else if (cnt == CW'(GAP_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign BUSY = (state != IDLE) || fifo_ne || hold_vld;

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Bench for ps2_key_serializer: decodes the serial line back into bytes and compares them with a queue
// built from the set-2 expansion rules, checking PS/2 timing, BUSY and OVERFLOW along the way.
`timescale 1ns/1ps
module tb_ps2_key_serializer;
    localparam int HALF  = 5;
    localparam int GAP   = 20;
    localparam int DEPTH = 8;
`ifdef PS2_TYPEMATIC_EN
    localparam int TMD = 1000;
    localparam int TMP = 500;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [10:0] key     = '0;
    logic        inhibit = 1'b0;
    logic        ps2_clk;
    logic        ps2_data;
    logic        busy;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ps2_key_serializer #(
        .CLK_HZ(1000),
        .PS2_HZ(100),
        .FIFO_DEPTH(DEPTH),
        .GAP_CYCLES(GAP)
`ifdef PS2_TYPEMATIC_EN
        ,
        .TM_DELAY(TMD),
        .TM_PERIOD(TMP)
`endif
    ) dut (
        .CLK50MHZ(clk),
        .COCO_RESET_N(rst_n),
        .PS2_KEY(key),
        .HOST_INHIBIT(inhibit),
        .PS2_CLK(ps2_clk),
        .PS2_DATA(ps2_data),
        .BUSY(busy),
        .OVERFLOW(ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- model state ----------------
    logic [7:0]  exp_q[$];
    logic [10:0] frame_log[$];
    int          rep_times[$];
    int          exp_ovf = 0, seen_ovf = 0, exp_abort = 0, seen_abort = 0, frames = 0, falls = 0;
    bit          allow_rep = 0;
    logic [7:0]  rep_code = 8'h00;
    logic        key_tog = 1'b0;

    task automatic send_key(input bit pressed, input bit ext, input logic [7:0] code);
        logic [7:0] b[$];
        if (ext)      b.push_back(8'hE0);
        if (!pressed) b.push_back(8'hF0);
        b.push_back(code);
        if (exp_q.size() + b.size() <= DEPTH) begin
            foreach (b[i]) exp_q.push_back(b[i]);
        end else begin
            exp_ovf++;
        end
        key_tog = ~key_tog;
        key     = {key_tog, pressed, ext, code};
    endtask

    // ---------------- line monitor / compare process ----------------
    logic        pc = 1'b1;
    logic        bit_at_fall = 1'b1;
    logic        ovf_prev = 1'b0;
    logic [10:0] sh = '0;
    int          hi_len = 0, lo_len = 0, idle_run = 0, nbits = 0, pend_run = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ps2_clk) begin
                if (!pc) check("clk_low_len", lo_len, HALF);
                hi_len++;
                lo_len = 0;
                if (nbits > 0 && hi_len > HALF) begin
                    seen_abort++;
                    nbits = 0;
                end
                idle_run = ps2_data ? idle_run + 1 : 0;
            end else begin
                if (pc) begin
                    if (nbits == 0) check("idle_before_start", hi_len >= HALF + GAP, 1);
                    else            check("clk_high_len", hi_len, HALF);
                    sh[nbits]   = ps2_data;
                    bit_at_fall = ps2_data;
                    nbits++;
                    falls++;
                    if (nbits == 11) begin
                        nbits = 0;
                        frames++;
                        frame_log.push_back(sh);
                        check("start_bit", sh[0], 0);
                        check("stop_bit", sh[10], 1);
                        check("odd_parity", $countones(sh[9:1]) % 2, 1);
                        if (allow_rep && sh[8:1] == rep_code && (exp_q.size() == 0 || exp_q[0] != sh[8:1])) begin
                            rep_times.push_back(cyc);
                        end else begin
                            check("byte_order", {1'b0, sh[8:1]}, exp_q.size() > 0 ? {1'b0, exp_q[0]} : 9'h100);
                            if (exp_q.size() > 0) void'(exp_q.pop_front());
                        end
                    end
                end else begin
                    check("data_stable_low", ps2_data, bit_at_fall);
                end
                lo_len++;
                hi_len   = 0;
                idle_run = 0;
            end
            pc = ps2_clk;

            pend_run = (exp_q.size() > 0) ? pend_run + 1 : 0;
            if (pend_run >= 2)
                check("busy_pending", busy, 1);
            else if (exp_q.size() == 0 && nbits == 0 && idle_run >= GAP + 3 && !allow_rep)
                check("busy_idle", busy, 0);
            if (ovf) begin
                seen_ovf++;
                check("ovf_one_cycle", ovf_prev, 0);
            end
            ovf_prev = ovf;
        end
    end

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain_in_time"}, n < budget, 1);
        repeat (GAP + 5) @(posedge clk);
        #1;
    endtask

    task automatic wait_bit(input string name, input int bitn);
        int n = 0;
        while (!(nbits == bitn && ps2_clk) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_reached_bit"}, n < 1000, 1);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int f0, ov0, fl0, t0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk", ps2_clk, 1);
        check("rst_data", ps2_data, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("idle_busy_after_reset", busy, 0);

        // 1: single make 0x1C
        f0 = frames; fl0 = falls;
        send_key(1, 0, 8'h1C);
        drain("t1", 3000);
        check("t1_frames", frames - f0, 1);
        check("t1_falls", falls - fl0, 11);
        check("t1_bits", frame_log[$], 11'b100_0011_1000);
        check("t1_busy_after_gap", busy, 0);
        send_key(0, 0, 8'h1C);
        drain("t1r", 3000);
        check("t1r_f0_frame", frame_log[$-1], 11'b111_1110_0000);

        // 2: extended release 0x75
        f0 = frames;
        send_key(0, 1, 8'h75);
        drain("t2", 3000);
        check("t2_frames", frames - f0, 3);
        check("t2_e0", frame_log[$-2], 11'b101_1100_0000);
        check("t2_f0", frame_log[$-1], 11'b111_1110_0000);
        check("t2_75", frame_log[$],   11'b100_1110_1010);

        // 3: overflow while inhibited
        inhibit = 1'b1;
        f0 = frames; ov0 = seen_ovf;
        @(posedge clk); #1;
        send_key(0, 1, 8'h11);
        repeat (2) @(posedge clk); #1;
        send_key(0, 1, 8'h14);
        repeat (2) @(posedge clk); #1;
        send_key(0, 1, 8'h12);
        repeat (100) @(posedge clk); #1;
        check("t3_ovf_pulses", seen_ovf - ov0, 1);
        check("t3_no_tx_inhibited", frames - f0, 0);
        check("t3_clk_held_idle", ps2_clk, 1);
        check("t3_busy", busy, 1);
        inhibit = 1'b0;
        drain("t3", 5000);
        check("t3_frames", frames - f0, 6);

        // 4: inhibit at bit index 5 aborts and resends
        f0 = frames;
        send_key(1, 0, 8'h1C);
        wait_bit("t4", 5);
        inhibit = 1'b1;
        exp_abort++;
        @(posedge clk); #1;
        check("t4_abort_clk", ps2_clk, 1);
        check("t4_abort_data", ps2_data, 1);
        repeat (60) @(posedge clk); #1;
        check("t4_held_clk", ps2_clk, 1);
        check("t4_busy_hold", busy, 1);
        check("t4_none_yet", frames - f0, 0);
        inhibit = 1'b0;
        drain("t4", 3000);
        check("t4_frames", frames - f0, 1);
        check("t4_bits", frame_log[$], 11'b100_0011_1000);
        send_key(0, 0, 8'h1C);
        drain("t4r", 3000);

        // 5: reset mid-frame
        f0 = frames;
        send_key(1, 0, 8'h2A);
        wait_bit("t5", 3);
        rst_n = 1'b0;
        exp_q.delete();
        exp_abort++;
        #1;
        check("t5_rst_clk", ps2_clk, 1);
        check("t5_rst_data", ps2_data, 1);
        check("t5_rst_busy", busy, 0);
        repeat (5) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (400) @(posedge clk); #1;
        check("t5_nothing_sent", frames - f0, 0);
        check("t5_busy", busy, 0);

`ifdef PS2_TYPEMATIC_EN
        // 6: typematic repeat of a held make, stopped by its break
        f0 = frames;
        rep_times.delete();
        rep_code  = 8'h1C;
        allow_rep = 1;
        t0 = cyc;
        send_key(1, 0, 8'h1C);
        repeat (2300) @(posedge clk); #1;
        allow_rep = 0;
        send_key(0, 0, 8'h1C);
        drain("t6", 3000);
        repeat (1500) @(posedge clk); #1;
        check("t6_rep_count", rep_times.size(), 3);
        if (rep_times.size() >= 1)
            check("t6_first_delay", (rep_times[0] - t0 >= TMD) && (rep_times[0] - t0 <= TMD + 22 * HALF + GAP), 1);
        for (int i = 1; i < rep_times.size(); i++)
            check("t6_period", (rep_times[i] - rep_times[i-1] >= TMP - 2) && (rep_times[i] - rep_times[i-1] <= TMP + 2), 1);
        check("t6_frames", frames - f0, 6);
        check("t6_last_f0", frame_log[$-1], 11'b111_1110_0000);
        check("t6_last_1c", frame_log[$], 11'b100_0011_1000);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        check("final_ovf_count", seen_ovf, exp_ovf);
        check("final_abort_count", seen_abort, exp_abort);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
